// File: rtl/io_port_ctrl.sv
// io_port_ctrl: handshake controller for one byte-wide input and output port.
// Optional wait-state timeout is built when IO_TIMEOUT_EN is defined.
module io_port_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic       g_clk,
    input  logic       g_clr,
    input  logic       in_req,
    input  logic       out_req,
    input  logic [7:0] out_data,
    input  logic       in_dev_hs,
    input  logic [7:0] input_bus,
    output logic       in_dev_ack,
    input  logic       out_dev_hs,
    input  logic       out_dev_ack,
    output logic       out_dev_valid,
    output logic [7:0] output_bus,
    output logic [7:0] in_data,
    output logic       io_busy,
    output logic       io_done,
    output logic       io_err,
    output logic [2:0] io_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IN_WAIT  = 3'd1,
        ST_IN_ACK   = 3'd2,
        ST_OUT_WAIT = 3'd3,
        ST_OUT_ACK  = 3'd4,
        ST_OUT_REL  = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_accept;
    logic       w_tmo;
    logic       r_in_ack;
    logic       r_out_valid;
    logic [7:0] r_in_data;
    logic [7:0] r_out_bus;

    assign w_accept = (r_state == ST_IDLE) && (in_req || out_req);

`ifdef IO_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_err;
    logic       w_wait;

    assign w_wait = r_state inside {ST_IN_WAIT, ST_IN_ACK, ST_OUT_WAIT,
                                    ST_OUT_ACK, ST_OUT_REL};
    assign w_tmo  = w_wait && (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Cycles spent in the current wait state; restarts on every transition.
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_cnt <= 8'd0;
        end else if (w_next != r_state) begin
            r_cnt <= 8'd0;
        end else if (w_wait) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Error flag sticks until the next request is accepted.
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_tmo) begin
            r_err <= 1'b1;
        end
    end

    assign io_err = r_err;
`else
    assign w_tmo  = 1'b0;
    assign io_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a timeout overrides any device progress.
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (in_req) begin
                    w_next = ST_IN_WAIT;
                end else if (out_req) begin
                    w_next = ST_OUT_WAIT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_IN_WAIT:  w_next = in_dev_hs   ? ST_IN_WAIT  : ST_IN_ACK;
            ST_IN_ACK:   w_next = in_dev_hs   ? ST_DONE     : ST_IN_ACK;
            ST_OUT_WAIT: w_next = out_dev_hs  ? ST_OUT_WAIT : ST_OUT_ACK;
            ST_OUT_ACK:  w_next = out_dev_ack ? ST_OUT_ACK  : ST_OUT_REL;
            ST_OUT_REL:  w_next = out_dev_ack ? ST_DONE     : ST_OUT_REL;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
        if (w_tmo) begin
            w_next = ST_DONE;
        end
    end

    // Registered strobes and data, derived from the state being entered.
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_in_ack    <= 1'b1;
            r_out_valid <= 1'b1;
            r_in_data   <= 8'd0;
            r_out_bus   <= 8'd0;
        end else begin
            r_in_ack    <= (w_next != ST_IN_ACK);
            r_out_valid <= (w_next != ST_OUT_ACK);
            if (r_state == ST_IN_WAIT && w_next == ST_IN_ACK) begin
                r_in_data <= input_bus;
            end
            if (r_state == ST_IDLE && w_next == ST_OUT_WAIT) begin
                r_out_bus <= out_data;
            end
        end
    end

    // Combinational status outputs.
    always_comb begin
        io_done = (r_state == ST_DONE);
        io_busy = ((r_state != ST_IDLE) && (r_state != ST_DONE)) ||
                  ((r_state == ST_IDLE) && (in_req || out_req));
        io_state = r_state;
    end

    assign in_dev_ack    = r_in_ack;
    assign out_dev_valid = r_out_valid;
    assign in_data       = r_in_data;
    assign output_bus    = r_out_bus;

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 200, SHALL give the wait-state abort limit in clock cycles; range 1..255.
REQ-002 g_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 g_clr  in  1  SHALL be the reset, asynchronous, active-low.
REQ-004 in_req  in  1  SHALL request an input transfer; level, held until io_done is seen.
REQ-005 out_req  in  1  SHALL request an output transfer; level, held until io_done is seen.
REQ-006 out_data  in  8  SHALL be the byte to send, sampled when out_req is accepted.
REQ-007 in_dev_hs  in  1  SHALL be the input-device handshake, active-low: input_bus is valid.
REQ-008 input_bus  in  8  SHALL be the input-device data.
REQ-009 in_dev_ack  out  1  SHALL be the acknowledge to the input device, active-low, registered.
REQ-010 out_dev_hs  in  1  SHALL be the output-device handshake, active-low: device ready.
REQ-011 out_dev_ack  in  1  SHALL be the output-device acknowledge, active-low: data taken.
REQ-012 out_dev_valid  out  1  SHALL be the output strobe, active-low, registered.
REQ-013 output_bus  out  8  SHALL be the registered output data.
REQ-014 in_data  out  8  SHALL be the last byte captured from input_bus.
REQ-015 io_busy  out  1  SHALL indicate a pipeline stall; combinational.
REQ-016 io_done  out  1  SHALL be a one-cycle completion pulse.
REQ-017 io_err  out  1  SHALL flag a timed-out transfer.
REQ-018 io_state  out  3  SHALL expose the state encoding for debug.

Function
REQ-019 States and encoding SHALL be IDLE=0, IN_WAIT=1, IN_ACK=2, OUT_WAIT=3, OUT_ACK=4, OUT_REL=5, DONE=6; code 7 SHALL go to IDLE.
REQ-020 IDLE: in_req=1 SHALL go to IN_WAIT; else out_req=1 SHALL go to OUT_WAIT and latch out_data into output_bus; in_req has priority when both are high.
REQ-021 IN_WAIT: in_dev_hs=0 SHALL capture input_bus into in_data, drive in_dev_ack=0 and go to IN_ACK.
REQ-022 IN_ACK: in_dev_ack SHALL stay 0 until in_dev_hs=1, then return to 1 and the FSM SHALL go to DONE.
REQ-023 OUT_WAIT: out_dev_hs=0 SHALL drive out_dev_valid=0 and go to OUT_ACK.
REQ-024 OUT_ACK: out_dev_ack=0 SHALL drive out_dev_valid=1 and go to OUT_REL.
REQ-025 OUT_REL: out_dev_ack=1 SHALL go to DONE; output_bus SHALL hold its value until the next accepted output.
REQ-026 DONE: io_done SHALL be 1 for exactly this cycle, then IDLE; requests SHALL be ignored in DONE.
REQ-027 io_busy SHALL equal (state not in {IDLE, DONE}) OR (state==IDLE AND (in_req OR out_req)).
REQ-028 A request still high in IDLE after DONE SHALL start a new transfer; no transfer SHALL be skipped or merged.
REQ-029 Minimum latency, device already asserted: request cycle to io_done SHALL be 3 cycles for input and 4 cycles for output.

Reset
REQ-030 g_clr=0 SHALL immediately force IDLE, in_dev_ack=1, out_dev_valid=1, output_bus=0, in_data=0, io_done=0, io_err=0, and timeout counter=0, including mid-transfer.
REQ-031 After reset release, the first rising edge SHALL evaluate IDLE transitions normally.

Configuration
REQ-032 Macro IO_TIMEOUT_EN defined: an 8-bit counter SHALL clear on each state change and increment each cycle in IN_WAIT, IN_ACK, OUT_WAIT, OUT_ACK and OUT_REL.
REQ-033 On reaching TIMEOUT_CYCLES, the controller SHALL set io_err=1, force in_dev_ack=1 and out_dev_valid=1, and go to DONE; in_data SHALL be unchanged.
REQ-034 io_err SHALL be sticky until the next accepted request clears it.
REQ-035 Macro IO_TIMEOUT_EN undefined: wait states SHALL wait indefinitely, io_err SHALL be tied to 0, and no counter SHALL be built.

Verification
REQ-036 Input with in_dev_hs=0 at request and input_bus=0x0A -> in_data=0x0A, in_dev_ack low for 1 cycle, io_done 3 cycles after in_req.
REQ-037 out_req with out_data=0xC3, device ready and acking -> output_bus=0xC3, out_dev_valid low until out_dev_ack=0, single io_done pulse.
REQ-038 in_req and out_req raised in the same cycle -> input completes first; output starts the cycle after the input's DONE, with io_busy continuous except during DONE.
REQ-039 g_clr=0 asserted in IN_ACK -> in_dev_ack=1 and io_state=0 before the next clock edge; no io_done.
REQ-040 IO_TIMEOUT_EN with TIMEOUT_CYCLES=10 and in_dev_hs held at 1 -> io_err=1 and io_done after 10 IN_WAIT cycles; io_err cleared by the next request.
